// File: rtl/elevator_pkg.sv
// Shared constants for the elevator controller: seven-segment patterns (a..g, active-low),
// elevator state encodings and default clock frequencies.
package elevator_pkg;

  localparam int DEFAULT_BOARD_FREQ  = 50000000;
  localparam int DEFAULT_MODULE_FREQ = 1;

  typedef enum logic [1:0] {
    WAIT = 2'b00,
    OPEN = 2'b01,
    DOWN = 2'b10,
    UP   = 2'b11
  } elevator_state_t;

  // Bit 6 is segment a, bit 0 is segment g; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit to seven-segment decoder (active-low a..g).
// Define SEVSEG_HEX_EN to show A-F for 10-15; otherwise those values are blanked.
module seg7_decoder
  import elevator_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_value)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
`ifdef SEVSEG_HEX_EN
      4'd10:   o_seg = SEG_A;
      4'd11:   o_seg = SEG_B;
      4'd12:   o_seg = SEG_C;
      4'd13:   o_seg = SEG_D;
      4'd14:   o_seg = SEG_E;
      4'd15:   o_seg = SEG_F;
`else
      default: o_seg = SEG_BLANK;
`endif
    endcase
  end

endmodule

// File: rtl/elevator_tick_display.sv
// Board-clock divider (50% duty divided clock plus rising-edge tick) and registered
// seven-segment display of input_num. SEVSEG_HEX_EN enables hex digits A-F in the decoder.
module elevator_tick_display
  import elevator_pkg::*;
#(
  parameter int BOARD_FREQ  = DEFAULT_BOARD_FREQ,
  parameter int MODULE_FREQ = DEFAULT_MODULE_FREQ
) (
  input  logic       board_clk,
  input  logic       rst,
  input  logic [3:0] input_num,
  output logic       clk,
  output logic       tick,
  output logic       seg_a,
  output logic       seg_b,
  output logic       seg_c,
  output logic       seg_d,
  output logic       seg_e,
  output logic       seg_f,
  output logic       seg_g
);

  localparam int HALF  = (MODULE_FREQ > 0) ? BOARD_FREQ / (2 * MODULE_FREQ) : 0;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'((HALF > 0) ? HALF - 1 : 0);

  if (MODULE_FREQ == 0 || HALF < 1) begin : g_bad_freq
    $error("elevator_tick_display: MODULE_FREQ must be nonzero and BOARD_FREQ/(2*MODULE_FREQ) >= 1");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk;
  logic             r_tick;
  logic [6:0]       r_seg;
  logic             w_term;
  logic [6:0]       w_seg;

  assign w_term = (r_cnt == TERM);

  // The tick is registered alongside the toggle so it lands in the cycle clk reads 1.
  always_ff @(posedge board_clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      if (w_term) begin
        r_cnt <= '0;
        r_clk <= ~r_clk;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_tick <= w_term & ~r_clk;
    end
  end

  seg7_decoder u_decoder (
    .i_value (input_num),
    .o_seg   (w_seg)
  );

  always_ff @(posedge board_clk) begin
    if (rst) begin
      r_seg <= SEG_BLANK;
    end else begin
      r_seg <= w_seg;
    end
  end

  assign clk   = r_clk;
  assign tick  = r_tick;
  assign seg_a = r_seg[6];
  assign seg_b = r_seg[5];
  assign seg_c = r_seg[4];
  assign seg_d = r_seg[3];
  assign seg_e = r_seg[2];
  assign seg_f = r_seg[1];
  assign seg_g = r_seg[0];

endmodule

// File: tb/tb_elevator_tick_display.sv
// Bench for elevator_tick_display: two instances (HALF=5 and HALF=1) checked every cycle
// against a cycle-count model, plus literal spot checks at the boundaries.
module tb_elevator_tick_display;

  localparam int HALF_A = 5;
  localparam int HALF_B = 1;

  logic       board_clk;
  logic       rstA, rstB;
  logic [3:0] numA, numB;
  logic       clkA, clkB, tickA, tickB;
  logic [6:0] segA, segB;

  int  errors = 0;
  int  checks = 0;
  bit  checkEn = 1'b0;

  int         nA = 0, nB = 0;
  logic [6:0] expSegA = 7'h7F, expSegB = 7'h7F;

  elevator_tick_display #(.BOARD_FREQ(10), .MODULE_FREQ(1)) dutA (
    .board_clk (board_clk), .rst (rstA), .input_num (numA),
    .clk (clkA), .tick (tickA),
    .seg_a (segA[6]), .seg_b (segA[5]), .seg_c (segA[4]), .seg_d (segA[3]),
    .seg_e (segA[2]), .seg_f (segA[1]), .seg_g (segA[0])
  );

  elevator_tick_display #(.BOARD_FREQ(2), .MODULE_FREQ(1)) dutB (
    .board_clk (board_clk), .rst (rstB), .input_num (numB),
    .clk (clkB), .tick (tickB),
    .seg_a (segB[6]), .seg_b (segB[5]), .seg_c (segB[4]), .seg_d (segB[3]),
    .seg_e (segB[2]), .seg_f (segB[1]), .seg_g (segB[0])
  );

  initial begin
    board_clk = 1'b0;
    forever #5 board_clk = ~board_clk;
  end

  // Reference segment table, written straight from the digit list.
  function automatic logic [6:0] segRef(input int v);
    logic [6:0] r;
    case (v)
      0: r = 7'b0000001;  1: r = 7'b1001111;  2: r = 7'b0010010;  3: r = 7'b0000110;
      4: r = 7'b1001100;  5: r = 7'b0100100;  6: r = 7'b0100000;  7: r = 7'b0001111;
      8: r = 7'b0000000;  9: r = 7'b0000100;
`ifdef SEVSEG_HEX_EN
      10: r = 7'b0001000; 11: r = 7'b1100000; 12: r = 7'b0110001;
      13: r = 7'b1000010; 14: r = 7'b0110000; 15: r = 7'b0111000;
`endif
      default: r = 7'b1111111;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rA, input logic rB, input logic [3:0] vA, input logic [3:0] vB);
    rstA = rA;
    rstB = rB;
    numA = vA;
    numB = vB;
  endtask

  // Model: edges since reset release fully determine clk and tick; segments follow input one edge late.
  always @(posedge board_clk) begin
    if (rstA) begin
      nA = 0;
      expSegA = 7'b1111111;
    end else begin
      nA = nA + 1;
      expSegA = segRef(int'(numA));
    end
    if (rstB) begin
      nB = 0;
      expSegB = 7'b1111111;
    end else begin
      nB = nB + 1;
      expSegB = segRef(int'(numB));
    end
  end

  always @(negedge board_clk) begin
    if (checkEn) begin
      checkOutput("clkA",  8'(clkA),  8'(((nA / HALF_A) % 2) == 1));
      checkOutput("tickA", 8'(tickA), 8'((nA % (2 * HALF_A)) == HALF_A));
      checkOutput("segA",  8'(segA),  8'(expSegA));
      checkOutput("clkB",  8'(clkB),  8'(((nB / HALF_B) % 2) == 1));
      checkOutput("tickB", 8'(tickB), 8'((nB % (2 * HALF_B)) == HALF_B));
      checkOutput("segB",  8'(segB),  8'(expSegB));
    end
  end

  initial begin
    applyStimulus(1'b1, 1'b1, 4'd8, 4'd8);
    repeat (3) @(negedge board_clk);
    checkEn = 1'b1;
    checkOutput("reset segA blank", 8'(segA), 8'h7F);
    checkOutput("reset clkA", 8'(clkA), 8'h00);
    checkOutput("reset tickA", 8'(tickA), 8'h00);

    applyStimulus(1'b0, 1'b0, 4'd8, 4'd8);
    for (int k = 1; k <= 18; k++) begin
      @(negedge board_clk);
      if (k == 1) begin
        checkOutput("first edge segA 8", 8'(segA), 8'h00);
        checkOutput("half1 clkB rise", 8'(clkB), 8'h01);
        checkOutput("half1 tickB rise", 8'(tickB), 8'h01);
      end
      if (k == 2) begin
        checkOutput("half1 clkB fall", 8'(clkB), 8'h00);
        checkOutput("half1 tickB low", 8'(tickB), 8'h00);
      end
      if (k == 4) checkOutput("clkA before rise", 8'(clkA), 8'h00);
      if (k == 5) begin
        checkOutput("clkA first rise", 8'(clkA), 8'h01);
        checkOutput("tickA first rise", 8'(tickA), 8'h01);
      end
      if (k == 6) checkOutput("tickA one cycle", 8'(tickA), 8'h00);
      if (k == 10) checkOutput("clkA fall", 8'(clkA), 8'h00);
      if (k == 15) checkOutput("tickA second rise", 8'(tickA), 8'h01);
      if (k == 18) checkOutput("clkA high at cnt3", 8'(clkA), 8'h01);
    end

    // Reset pulse while clk is high with the counter at 3.
    applyStimulus(1'b1, 1'b0, 4'd3, 4'd3);
    @(negedge board_clk);
    checkOutput("midreset clkA", 8'(clkA), 8'h00);
    checkOutput("midreset segA", 8'(segA), 8'h7F);
    applyStimulus(1'b0, 1'b0, 4'd3, 4'd3);
    for (int k = 1; k <= 5; k++) begin
      @(negedge board_clk);
      if (k == 4) checkOutput("post reset clkA low", 8'(clkA), 8'h00);
      if (k == 5) checkOutput("post reset tickA", 8'(tickA), 8'h01);
    end

    for (int v = 0; v <= 9; v++) begin
      applyStimulus(1'b0, 1'b0, 4'(v), 4'(9 - v));
      @(negedge board_clk);
      if (v == 0) checkOutput("digit 0", 8'(segA), 8'b00000001);
      if (v == 7) checkOutput("digit 7", 8'(segA), 8'b00001111);
    end

    applyStimulus(1'b0, 1'b0, 4'd12, 4'd15);
    @(negedge board_clk);
`ifdef SEVSEG_HEX_EN
    checkOutput("value 12", 8'(segA), 8'b00110001);
`else
    checkOutput("value 12", 8'(segA), 8'b01111111);
`endif

    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      @(negedge board_clk);
    end

    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
    @(negedge board_clk);
    checkEn = 1'b0;
    @(negedge board_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
